imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the instruction memory from a byte stream before the core runs. It accepts a framed byte stream on a valid/ready interface, assembles little-endian 32-bit words and drives a one-word-per-cycle write port into instruction memory. It holds the core in reset (`cpu_hold`) while a load is in progress. It sits between the boot/debug byte source (e.g. a UART receiver) and the write side of the instruction memory.

## Interface
- `Memory_Depth`, 1024: instruction memory depth in words. `AW` = $clog2(Memory_Depth).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load session.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte; a transfer occurs when `rx_valid && rx_ready`.
- `wr_en`  out  1  instruction memory write strobe, one cycle per word.
- `wr_addr`  out  AW  word address.
- `wr_data`  out  32  word to write.
- `cpu_hold`  out  1  hold the core in reset.
- `busy`  out  1  load session in progress.
- `done`  out  1  session finished (sticky).
- `error`  out  1  session failed (sticky).

## Operation
- Frame format:
  - N_lo, N_hi: 16-bit word count, little-endian.
  - N×4 payload bytes, each word least-significant byte first.
  - One checksum byte equal to the XOR of all payload bytes. The header is excluded. For N=0 the checksum is 0x00.
- States:
  - IDLE: wait for `start`.
  - HDR0: accept N_lo.
  - HDR1: accept N_hi.
  - DATA: accept payload bytes.
  - CSUM: accept the checksum byte.
  - FIN: report the result.
- `rx_ready`=1 exactly in HDR0, HDR1, DATA and CSUM. All outputs are registered.
- Transitions:
  - IDLE/FIN + `start` → HDR0. This clears `done`, `error`, the byte counter, the word index and the running XOR.
  - HDR0 + transfer → HDR1.
  - HDR1 + transfer:
    - N > Memory_Depth → FIN with `error`=1. Nothing is written.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - DATA: a 2-bit byte lane counter shifts each byte into lane 0..3. On the lane-3 transfer the word is registered and issued as a write. The word index increments after each write. After the N-th word → CSUM.
  - CSUM + transfer → FIN. `done`=1 and `error`=(byte ≠ running XOR).
- `start` is ignored in HDR0, HDR1, DATA and CSUM.
- `busy`=1 in HDR0, HDR1, DATA and CSUM.
- `cpu_hold`:
  - Set on entry to HDR0.
  - Cleared on FIN entry when `error`=0.
  - Remains 1 after an error until the next successful session or reset.
- N = Memory_Depth is legal; the last word is written to address Memory_Depth-1. No address wrap occurs.
- Payload bytes that reach memory are not rolled back on a checksum error.
- Reset (`rst`=0) at any cycle:
  - State returns to IDLE.
  - Any partial word is discarded and no write is issued.
  - Every output is 0: `rx_ready`, `wr_en`, `wr_addr`, `wr_data`, `cpu_hold`, `busy`, `done`, `error`.
  - A core may therefore boot from memory preloaded by other means.

## Timing
- `start` sampled high at cycle t → at t+1: state HDR0, `rx_ready`=1, `busy`=1, `cpu_hold`=1.
- Lane-3 byte transferred at t → at t+1: `wr_en`=1 for exactly one cycle, with `wr_addr` = word index and `wr_data` = assembled word. `wr_addr`/`wr_data` hold their values until the next write.
- The loader accepts one byte per cycle at full rate. A stalled `rx_valid` inserts no extra writes and loses no bytes.
- Last payload byte at t → `wr_en` at t+1 and CSUM (`rx_ready`=1) at t+1. The final write and the checksum acceptance may overlap.
- N_hi transfer at t with N > Memory_Depth → at t+1: FIN, `done`=1, `error`=1, `busy`=0, `rx_ready`=0.
- Checksum transfer at t → at t+1: `done`=1, `busy`=0, `rx_ready`=0, `error` valid, `cpu_hold`=`error`.
- Minimum session for N words: 3 + 4N transfer cycles, plus the `start` cycle.

## Test plan
- Good load:
  - Stimulus: reset, `start`, then bytes 02 00 | 13 00 00 00 | EF BE AD DE | 31.
  - Required: writes (0, 0x00000013) and (1, 0xDEADBEEF), one `wr_en` cycle each; then `done`=1, `error`=0, `cpu_hold`=0, `rx_ready`=0.
- Bad checksum:
  - Stimulus: the good-load frame with a final byte of 30.
  - Required: both writes still occur; `done`=1, `error`=1, `cpu_hold`=1.
- Count overflow:
  - Stimulus: header 01 04 (N=1025).
  - Required: the next cycle has `error`=1, `done`=1, `rx_ready`=0, and no `wr_en`.
  - Stimulus: header 00 04 (N=1024), then 4096 payload bytes and a correct checksum.
  - Required: last write at address 1023, `error`=0.
- Backpressure:
  - Stimulus: the good-load frame with random 0–3 cycle `rx_valid` gaps.
  - Required: the same two writes and result. `wr_en` is never high for two consecutive cycles within a word.
- Reset mid-word:
  - Stimulus: pull `rst` low after 02 00 13 00.
  - Required: no write occurs and all outputs read 0.
  - Stimulus: then `start` with a 1-word frame 01 00 | 78 56 34 12 | 08.
  - Required: writes (0, 0x12345678) and `done`=1.
- Edge controls:
  - Stimulus: frame 00 00 | 00.
  - Required: `done`=1 with no writes.
  - Stimulus: `start` pulsed while in DATA.
  - Required: the session continues unaffected.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory program loader: takes a framed byte stream, assembles
// little-endian words, writes them to imem and holds the core while loading.
module imem_loader #(
  parameter int Memory_Depth = 1024,
  localparam int AW = $clog2(Memory_Depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam logic [16:0] DEPTH = 17'(Memory_Depth);

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_nlo;
  logic [15:0]   r_cnt;
  logic [15:0]   r_widx;
  logic [1:0]    r_lane;
  logic [23:0]   r_word;
  logic [7:0]    r_xor;
  logic          r_rx_ready;
  logic          r_busy;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_cpu_hold;
  logic          r_done;
  logic          r_error;

  logic          w_xfer;
  logic [15:0]   w_n;
  logic          w_n_over;
  logic          w_n_zero;
  logic          w_last_word;
  logic          w_next_active;

  assign w_xfer      = rx_valid && r_rx_ready;
  assign w_n         = {rx_data, r_nlo};
  assign w_n_over    = {1'b0, w_n} > DEPTH;
  assign w_n_zero    = (w_n == '0);
  assign w_last_word = (r_widx == r_cnt - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, FIN: if (start) w_next = HDR0;
      HDR0:      if (w_xfer) w_next = HDR1;
      HDR1: begin
        if (w_xfer) begin
          if (w_n_over)      w_next = FIN;
          else if (w_n_zero) w_next = CSUM;
          else               w_next = DATA;
        end
      end
      DATA:      if (w_xfer && r_lane == 2'd3 && w_last_word) w_next = CSUM;
      CSUM:      if (w_xfer) w_next = FIN;
      default:   w_next = IDLE;
    endcase
  end

  // rx_ready/busy are registered from the next state so they track r_state exactly
  assign w_next_active = (w_next == HDR0) || (w_next == HDR1) ||
                         (w_next == DATA) || (w_next == CSUM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_nlo      <= '0;
      r_cnt      <= '0;
      r_widx     <= '0;
      r_lane     <= '0;
      r_word     <= '0;
      r_xor      <= '0;
      r_rx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_rx_ready <= w_next_active;
      r_busy     <= w_next_active;
      case (r_state)
        IDLE, FIN: begin
          if (start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_lane     <= '0;
            r_widx     <= '0;
            r_xor      <= '0;
            r_cpu_hold <= 1'b1;
          end
        end
        HDR0: if (w_xfer) r_nlo <= rx_data;
        HDR1: begin
          if (w_xfer) begin
            r_cnt <= w_n;
            if (w_n_over) begin
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_xor  <= r_xor ^ rx_data;
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_widx[AW-1:0];
              r_wr_data <= {rx_data, r_word};
              r_widx    <= r_widx + 16'd1;
            end else begin
              // lanes shift in from the top so lane 0 ends up in bits [7:0]
              r_word <= {rx_data, r_word[23:8]};
            end
          end
        end
        CSUM: begin
          if (w_xfer) begin
            r_done     <= 1'b1;
            r_error    <= (rx_data != r_xor);
            r_cpu_hold <= (rx_data != r_xor);
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready = r_rx_ready;
  assign busy     = r_busy;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized sessions
// compared against a queue-based frame model.
module tb_imem_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;
  int consec = 0;
  logic prev_wr = 1'b0;

  logic [7:0]  pay[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  imem_loader #(.Memory_Depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(32'(wr_addr));
      wd_q.push_back(wr_data);
    end
    if (wr_en && prev_wr) consec++;
    prev_wr = wr_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
    int budget;
    logic ok;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, gap)) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    start    = st;
    budget   = 50;
    forever begin
      ok = rx_ready;
      tick();
      if (ok) break;
      budget--;
      if (budget == 0) begin
        chk("rx_ready_wait", 32'(ok), 32'd1);
        break;
      end
    end
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  function automatic logic [7:0] model_xor();
    logic [7:0] x = '0;
    foreach (pay[i]) x ^= pay[i];
    return x;
  endfunction

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
  endtask

  // One full session: start pulse, header, payload from pay[], checksum byte.
  task automatic run_session(input string tag, input int n, input logic [7:0] csum,
                             input int gap, input int start_idx);
    logic [7:0]  frame[$];
    logic [15:0] nn;
    logic        exp_err;
    int          exp_w;
    nn = 16'(n);
    wa_q.delete();
    wd_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy0"},  32'(busy),     32'd1);
    chk({tag, ".rdy0"},   32'(rx_ready), 32'd1);
    chk({tag, ".hold0"},  32'(cpu_hold), 32'd1);
    chk({tag, ".done0"},  32'(done),     32'd0);
    frame.push_back(nn[7:0]);
    frame.push_back(nn[15:8]);
    if (n <= DEPTH) begin
      foreach (pay[i]) frame.push_back(pay[i]);
      frame.push_back(csum);
    end
    foreach (frame[i]) send_byte(frame[i], gap, (i == start_idx));
    exp_err = (n > DEPTH) || (csum != model_xor());
    exp_w   = (n > DEPTH) ? 0 : n;
    chk({tag, ".done"},  32'(done),     32'd1);
    chk({tag, ".error"}, 32'(error),    32'(exp_err));
    chk({tag, ".busy"},  32'(busy),     32'd0);
    chk({tag, ".rdy"},   32'(rx_ready), 32'd0);
    chk({tag, ".hold"},  32'(cpu_hold), 32'(exp_err));
    @(negedge clk);
    #1;
    chk({tag, ".nwr"}, 32'(wa_q.size()), 32'(exp_w));
    for (int i = 0; i < exp_w && i < wa_q.size(); i++) begin
      chk({tag, ".addr"}, wa_q[i], 32'(i));
      chk({tag, ".data"}, wd_q[i], {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]});
    end
    chk({tag, ".consec"}, 32'(consec), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst.rdy",  32'(rx_ready), 32'd0);
    chk("rst.busy", 32'(busy),     32'd0);
    chk("rst.hold", 32'(cpu_hold), 32'd0);
    chk("rst.wr",   {31'd0, wr_en} | 32'(wr_addr) | wr_data, 32'd0);
    rst = 1'b1;
    tick();

    pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_session("good", 2, 8'h31, 0, -1);
    chk("good.w1", (wa_q.size() == 2) ? wd_q[1] : 32'hx, 32'hDEADBEEF);
    run_session("badcs", 2, 8'h30, 0, -1);
    run_session("bp", 2, 8'h31, 3, -1);
    run_session("startdata", 2, 8'h31, 0, 4);

    pay.delete();
    run_session("ovf", 1025, 8'h00, 0, -1);
    run_session("zero", 0, 8'h00, 0, -1);

    fill_random(DEPTH);
    run_session("full", DEPTH, model_xor(), 0, -1);
    chk("full.last", (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 32'hx, 32'd1023);

    // reset in the middle of the first word
    wa_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h13, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    rst = 1'b0;
    tick();
    chk("mrst.outs", {24'd0, rx_ready, wr_en, cpu_hold, busy, done, error, 2'b00}, 32'd0);
    chk("mrst.addr", 32'(wr_addr) | wr_data, 32'd0);
    @(negedge clk);
    chk("mrst.nwr", 32'(wa_q.size()), 32'd0);
    rst = 1'b1;
    tick();
    pay = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_session("post", 1, 8'h08, 0, -1);

    for (int k = 0; k < 6; k++) begin
      int n;
      logic [7:0] cs;
      n = $urandom_range(1, 6);
      fill_random(n);
      cs = model_xor();
      if ($urandom_range(0, 1) == 1) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      run_session("rand", n, cs, 3, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
